// File: rtl/sigdel_channel_scheduler_if.sv
// Sample-write handshake and tagged-bitstream bundle for sigdel_channel_scheduler.
// master = sample/mask producer and bit consumer, slave = the scheduler.
interface sigdel_channel_scheduler_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 24,
  parameter int CH_IDX_WIDTH = 2
);
  logic [NUM_CHANNELS-1:0] chan_enable;
  logic                    sample_valid;
  logic                    sample_ready;
  logic [CH_IDX_WIDTH-1:0] sample_channel;
  logic [DATA_WIDTH-1:0]   sample_data;
  logic                    bit_valid;
  logic [CH_IDX_WIDTH-1:0] bit_channel;
  logic                    output_bitstream;
  logic                    frame_start;
  logic                    addr_error;

  modport master (
    output chan_enable, sample_valid, sample_channel, sample_data,
    input  sample_ready, bit_valid, bit_channel, output_bitstream, frame_start, addr_error
  );

  modport slave (
    input  chan_enable, sample_valid, sample_channel, sample_data,
    output sample_ready, bit_valid, bit_channel, output_bitstream, frame_start, addr_error
  );
endinterface

// File: rtl/sigdel_channel_scheduler.sv
// Round-robin time-multiplexed first-order sigma-delta modulator with double-buffered samples.
// Optional feature: define SIGDEL_DITHER_EN to add a 16-bit LFSR dither bit to every update.
module sigdel_channel_scheduler #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 24,
  parameter int CH_IDX_WIDTH = 2
) (
  input  logic clock_200,
  input  logic reset_n,
  sigdel_channel_scheduler_if.slave bus
);

  localparam int unsigned NUM_U = NUM_CHANNELS;

  logic [NUM_CHANNELS-1:0] pending_q, pending_d;
  logic [DATA_WIDTH-1:0]   shadow_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   shadow_d [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   active_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   active_d [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   acc_q    [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   acc_d    [NUM_CHANNELS];
  logic [CH_IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic                    bit_valid_q, bit_valid_d;
  logic [CH_IDX_WIDTH-1:0] bit_channel_q, bit_channel_d;
  logic                    bit_q, bit_d;
  logic                    frame_start_q, frame_start_d;
  logic                    addr_error_q, addr_error_d;

  logic                    sel_found;
  logic [CH_IDX_WIDTH-1:0] sel;
  int unsigned             cand;
  logic                    ready;
  logic                    in_range;
  logic                    dither;
  logic [DATA_WIDTH:0]     sum;

`ifdef SIGDEL_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    dither = lfsr_q[0];
    lfsr_d = lfsr_q;
    if (sel_found) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clock_200) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end
`else
  always_comb dither = 1'b0;
`endif

  // First enabled channel strictly after ptr_q, scanning upward with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NUM_U; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NUM_U) cand = cand - NUM_U;
      for (int unsigned i = 0; i < NUM_U; i++) begin
        if (!sel_found && (i == cand) && bus.chan_enable[i]) begin
          sel_found = 1'b1;
          sel       = CH_IDX_WIDTH'(i);
        end
      end
    end
  end

  // Out-of-range channels match no entry, so they stay ready and flag addr_error.
  always_comb begin
    ready    = 1'b1;
    in_range = 1'b0;
    for (int unsigned i = 0; i < NUM_U; i++) begin
      if (i == 32'(bus.sample_channel)) begin
        ready    = !pending_q[i];
        in_range = 1'b1;
      end
    end
  end

  always_comb begin
    pending_d     = pending_q;
    shadow_d      = shadow_q;
    active_d      = active_q;
    acc_d         = acc_q;
    ptr_d         = ptr_q;
    bit_valid_d   = 1'b0;
    bit_channel_d = bit_channel_q;
    bit_d         = bit_q;
    frame_start_d = 1'b0;
    addr_error_d  = addr_error_q;
    sum           = '0;

    for (int unsigned i = 0; i < NUM_U; i++) begin
      if (!bus.chan_enable[i]) acc_d[i] = '0;
    end

    if (sel_found) begin
      ptr_d         = sel;
      bit_valid_d   = 1'b1;
      bit_channel_d = sel;
      // bit_valid_q low means the previous cycle was idle or reset.
      frame_start_d = !bit_valid_q || (sel <= ptr_q);
      for (int unsigned i = 0; i < NUM_U; i++) begin
        if (i == 32'(sel)) begin
          if (pending_q[i]) begin
            active_d[i]  = shadow_q[i];
            pending_d[i] = 1'b0;
          end
          sum = {1'b0, acc_q[i]}
              + {1'b0, ~active_q[i][DATA_WIDTH-1], active_q[i][DATA_WIDTH-2:0]}
              + (DATA_WIDTH+1)'(dither);
          bit_d    = sum[DATA_WIDTH];
          acc_d[i] = sum[DATA_WIDTH-1:0];
        end
      end
    end

    if (bus.sample_valid && ready) begin
      if (in_range) begin
        for (int unsigned i = 0; i < NUM_U; i++) begin
          if (i == 32'(bus.sample_channel)) begin
            shadow_d[i]  = bus.sample_data;
            pending_d[i] = 1'b1;
          end
        end
      end else begin
        addr_error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_200) begin
    if (!reset_n) begin
      pending_q     <= '0;
      for (int unsigned i = 0; i < NUM_U; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        acc_q[i]    <= '0;
      end
      ptr_q         <= CH_IDX_WIDTH'(NUM_CHANNELS - 1);
      bit_valid_q   <= 1'b0;
      bit_channel_q <= '0;
      bit_q         <= 1'b0;
      frame_start_q <= 1'b0;
      addr_error_q  <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      acc_q         <= acc_d;
      ptr_q         <= ptr_d;
      bit_valid_q   <= bit_valid_d;
      bit_channel_q <= bit_channel_d;
      bit_q         <= bit_d;
      frame_start_q <= frame_start_d;
      addr_error_q  <= addr_error_d;
    end
  end

  assign bus.sample_ready     = ready;
  assign bus.bit_valid        = bit_valid_q;
  assign bus.bit_channel      = bit_channel_q;
  assign bus.output_bitstream = bit_q;
  assign bus.frame_start      = frame_start_q;
  assign bus.addr_error       = addr_error_q;

endmodule
